// File: rtl/bcd_7seg_display.sv
// bcd_7seg_display: signed binary to four-digit 7-segment driver with sign flag.
// Revision 1.0 - initial release.
`default_nettype none

module bcd_7seg_display #(
  parameter int IN_W     = 12,
  parameter int N_DIGITS = 4,
  parameter int SEG_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_W-1:0]           in_Bin,
  output logic [N_DIGITS*SEG_W-1:0] out_displays,
  output logic                      out_Signo
);

  localparam int               BCD_W    = 4 * N_DIGITS;
  localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;

  logic                      sign;
  logic [IN_W-1:0]           mag;
  logic [BCD_W-1:0]          bcd;
  logic [N_DIGITS*SEG_W-1:0] seg_next;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the display.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Unsigned magnitude; -2048 maps to 12'h800 which still reads as 2048.
  assign sign = in_Bin[IN_W-1];
  assign mag  = sign ? ((~in_Bin) + {{(IN_W-1){1'b0}}, 1'b1}) : in_Bin;

  always_comb begin
    bcd = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[BCD_W-2:0], mag[i]};
    end
  end

  generate
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
      assign seg_next[g*SEG_W +: SEG_W] = seg_decode(bcd[4*g +: 4]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_displays <= {N_DIGITS{SEG_ZERO}};
      out_Signo    <= 1'b0;
    end else begin
      out_displays <= seg_next;
      out_Signo    <= sign;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_7seg_display.sv
// tb_bcd_7seg_display: directed literal checks plus randomized stream against a decimal model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_bcd_7seg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_Bin;
  logic [27:0] out_displays;
  logic        out_Signo;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  bcd_7seg_display #(.IN_W(12), .N_DIGITS(4), .SEG_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_Bin       (in_Bin),
    .out_displays (out_displays),
    .out_Signo    (out_Signo)
  );

  always #5 clk = ~clk;

  // Expected {sign, displays} computed with ordinary decimal arithmetic.
  function automatic logic [28:0] model(input logic [11:0] v);
    int iv;
    int m;
    iv = int'($signed(v));
    m  = (iv < 0) ? -iv : iv;
    return {iv < 0, SEG_TAB[(m / 1000) % 10], SEG_TAB[(m / 100) % 10],
            SEG_TAB[(m / 10) % 10], SEG_TAB[m % 10]};
  endfunction

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got sign=%b disp=%b, expected sign=%b disp=%b",
               name, act[28], act[27:0], exp[28], exp[27:0]);
    end
  endtask

  // Model tracks every edge; compare process checks on the falling edge.
  logic [28:0] exp_out;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    model_valid <= 1'b1;
    exp_out     <= rst ? {1'b0, {4{SEG_TAB[0]}}} : model(in_Bin);
  end

  always @(negedge clk) begin
    if (model_valid) check("model", {out_Signo, out_displays}, exp_out);
  end

  task automatic put(input logic [11:0] v);
    in_Bin = v;
    @(posedge clk);
    #1;
  endtask

  localparam logic [27:0] RST_PAT = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  initial begin
    rst    = 1'b1;
    in_Bin = 12'hE25;
    @(posedge clk); #1;
    check("reset_cycle1", {out_Signo, out_displays}, {1'b0, RST_PAT});
    @(posedge clk); #1;
    check("reset_cycle2", {out_Signo, out_displays}, {1'b0, RST_PAT});
    rst = 1'b0;
    @(posedge clk); #1;
    check("neg475", {out_Signo, out_displays},
          {1'b1, 7'b1000000, 7'b0011001, 7'b1111000, 7'b0010010});

    // Back-to-back directed values, each visible exactly one edge later.
    put(12'sd2039);
    check("pos2039", {out_Signo, out_displays},
          {1'b0, 7'b0100100, 7'b1000000, 7'b0110000, 7'b0010000});
    put(-12'sd1097);
    check("neg1097", {out_Signo, out_displays},
          {1'b1, 7'b1111001, 7'b1000000, 7'b0010000, 7'b1111000});
    put(12'sd8);
    check("pos8", {out_Signo, out_displays},
          {1'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0000000});
    put(12'h800);
    check("min_neg2048", {out_Signo, out_displays},
          {1'b1, 7'b0100100, 7'b1000000, 7'b0011001, 7'b0000000});
    put(12'h7FF);
    check("max2047", {out_Signo, out_displays},
          {1'b0, 7'b0100100, 7'b1000000, 7'b0011001, 7'b1111000});
    put(12'h000);
    check("zero", {out_Signo, out_displays}, {1'b0, RST_PAT});
    put(12'hFFF);
    check("neg1", {out_Signo, out_displays},
          {1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001});

    // Mid-stream reset drops the pending sample.
    in_Bin = 12'sd1234;
    rst    = 1'b1;
    @(posedge clk); #1;
    check("midstream_reset", {out_Signo, out_displays}, {1'b0, RST_PAT});
    rst = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      rst    = ($urandom_range(0, 31) == 0);
      in_Bin = 12'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_7seg_display.md
Name: bcd_7seg_display

Overview:
- Converts a signed two's-complement binary value into four decimal digits (thousands, hundreds, tens, units) and drives one 7-segment pattern per digit, plus a separate sign flag.
- Sits between the datapath result bus and the board's four 7-segment displays and minus-sign indicator.
- Registered output stage; purely synchronous.

Parameters:
- IN_W, 12, width of the signed input. The supported range is -2048..2047.
- N_DIGITS, 4, number of decimal digits / displays. The value is fixed at 4 for IN_W=12.
- SEG_W, 7, segments per display.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_Bin  input  12  signed two's-complement value to display (t_iv).
- out_displays  output  28  segment patterns (t_display):
  - [27:21] thousands
  - [20:14] hundreds
  - [13:7] tens
  - [6:0] units
- out_Signo  output  1  sign flag: 1 = negative, 0 = zero or positive.

Behaviour:
- Reset: when rst=1 at a rising clk edge:
  - every digit field of out_displays is loaded with the pattern for "0" (7'b1000000);
  - out_Signo=0.
  - Reset has priority over sampling in_Bin.
  - Reset applied mid-stream discards the pending conversion.
- Latency: exactly 1 clock. in_Bin is sampled at edge N, and its outputs are valid after edge N. Throughput is one new value per clock. No handshake.
- Sign: sign = in_Bin[11]. Magnitude = sign ? (~in_Bin + 1) : in_Bin, computed 12 bits wide, unsigned.
  - -2048 gives magnitude 2048, which must not overflow. Use a 12-bit unsigned magnitude, max 2048.
- Binary-to-BCD conversion: combinational shift-add-3 (double dabble) over 12 iterations into 16 BCD bits (4 nibbles).
  - Before each shift, any nibble >= 5 gets +3.
  - The thousands nibble never exceeds 2.
- Digit decode: each nibble maps to an active-low segment code, bit order {g,f,e,d,c,b,a} (bit6=g, bit0=a).
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Nibble values 10-15 are unreachable; they decode to all-off (1111111).
- Leading zeros are displayed; there is no blanking. Example: 8 shows "0008".
- Zero: in_Bin=0 gives "0000" with out_Signo=0. There is no negative zero.
- out_displays and out_Signo update together on the same edge; they are never from different samples.
- No X propagation: all outputs are driven from flops with defined reset values.

Test Plan:
- Reset: assert rst for 2 cycles with in_Bin=-475. Then out_displays = {1000000,1000000,1000000,1000000} and out_Signo=0. After release, one edge later the outputs show the converted value.
- in_Bin=-475 (12'hE25) -> digits 0,4,7,5 = {1000000,0011001,1111000,0010010}, out_Signo=1, valid 1 cycle after sampling.
- in_Bin=2039 -> digits 2,0,3,9 = {0100100,1000000,0110000,0010000}, out_Signo=0.
- in_Bin=-1097 -> digits 1,0,9,7 = {1111001,1000000,0010000,1111000}, out_Signo=1.
- in_Bin=8 -> digits 0,0,0,8 = {1000000,1000000,1000000,0000000}, out_Signo=0 (leading zeros shown).
- Boundaries:
  - -2048 -> 2,0,4,8 with out_Signo=1.
  - 2047 -> 2,0,4,7 with out_Signo=0.
  - 0 -> 0000 with out_Signo=0.
  - -1 -> 0001 with out_Signo=1.
  - Back-to-back values on consecutive cycles each appear exactly one cycle later, in order.
